// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/lc3_bytelane_ram.sv
// Single-port 16-bit array with per-byte write enables and a registered read port.
module lc3_bytelane_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Wait-stated SRAM-style responder: byte-lane array access plus one memory-mapped I/O word
// (switch readback, hex display register).
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_SRAM,
  input  logic [9:0]  SW,
  output logic [15:0] Data_from_SRAM,
  output logic        Mem_ready,
  output logic [15:0] HEX_out
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wdata_q;
  logic               ub_q;
  logic               lb_q;
  logic               wr_q;
  logic               io_q;
  logic               ready_q;
  logic [15:0]        hex_q;
  logic               rd_ram_q;
  logic [15:0]        rd_io_q;
  logic [15:0]        ram_rdata;

  logic req;
  logic rel;
  logic commit;
  logic ram_we;
  logic ram_re;

  assign req    = !CE && (!OE || !WE);
  assign rel    = CE || (OE && WE);
  assign commit = (state == BUSY) && (cnt == '0);
  assign ram_we = commit && wr_q && !io_q;
  assign ram_re = commit && !wr_q && !io_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      ready_q  <= 1'b0;
      hex_q    <= '0;
      rd_ram_q <= 1'b0;
      rd_io_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= ADDR[ADDR_W-1:0];
            wdata_q <= Data_to_SRAM;
            ub_q    <= UB;
            lb_q    <= LB;
            wr_q    <= !WE;
            io_q    <= (ADDR == IO_ADDR);
            cnt     <= CNT_W'(WAIT_STATES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ready_q <= 1'b1;
            state   <= DONE;
            if (!wr_q) begin
              // Read data source is remembered so the output holds until the next read.
              if (io_q) begin
                rd_io_q  <= {6'b0, SW};
                rd_ram_q <= 1'b0;
              end else begin
                rd_ram_q <= 1'b1;
              end
            end else if (io_q) begin
              if (!ub_q) hex_q[15:8] <= wdata_q[15:8];
              if (!lb_q) hex_q[7:0]  <= wdata_q[7:0];
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          if (rel) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lc3_bytelane_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .be    (~{ub_q, lb_q}),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign Data_from_SRAM = rd_ram_q ? ram_rdata : rd_io_q;
  assign Mem_ready      = ready_q;
  assign HEX_out        = hex_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: two responders (0 and 2 wait states) driven by the same strobes.
module tb_lc3_mem_responder;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        CE = 1'b1, OE = 1'b1, WE = 1'b1, UB = 1'b1, LB = 1'b1;
  logic [15:0] ADDR = '0, Data_to_SRAM = '0;
  logic [9:0]  SW = 10'h2A5;
  logic [15:0] data, hex, data0, hex0;
  logic        ready, ready0;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .SW(SW),
    .Data_from_SRAM(data), .Mem_ready(ready), .HEX_out(hex)
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .SW(SW),
    .Data_from_SRAM(data0), .Mem_ready(ready0), .HEX_out(hex0)
  );

  typedef struct {
    logic        wr;
    logic        both;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ub;
    logic        lb;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    @(negedge Clk);
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    @(posedge Clk);
  endtask

  // Drive one request, measure Mem_ready latency of both DUTs, then release.
  task automatic access(input vec_t v, output int lat, output int lat0,
                        output logic [15:0] rd, output logic [15:0] rd0);
    @(negedge Clk);
    CE = 1'b0;
    OE = (v.wr && !v.both) ? 1'b1 : 1'b0;
    WE = v.wr ? 1'b0 : 1'b1;
    ADDR = v.addr; Data_to_SRAM = v.wdata; UB = v.ub; LB = v.lb;
    @(posedge Clk);
    lat = -1; lat0 = -1; rd = 'x; rd0 = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (ready0 && lat0 < 0) begin lat0 = i; rd0 = data0; end
      if (ready && lat < 0) begin lat = i; rd = data; end
      if (lat >= 0 && lat0 >= 0) break;
    end
    release_bus();
  endtask

  vec_t vecs[15];
  vec_t v;
  int   lat, lat0, n, n0;
  logic [15:0] rd, rd0;

  initial begin
    //         wr    both  addr      wdata     ub    lb    exp_rd    exp_hex
    vecs[0]  = '{1'b1, 1'b0, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0006, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0006, 16'hAB00, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'hAB34, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h02A5, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'hFFFF, 16'h00C3, 1'b0, 1'b0, 16'h02A5, 16'h00C3};
    vecs[7]  = '{1'b1, 1'b0, 16'h0405, 16'h0777, 1'b0, 1'b0, 16'h02A5, 16'h00C3};
    vecs[8]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0777, 16'h00C3};
    vecs[9]  = '{1'b1, 1'b1, 16'h0010, 16'h5A5A, 1'b0, 1'b0, 16'h0777, 16'h00C3};
    vecs[10] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 16'h00C3};
    vecs[11] = '{1'b1, 1'b0, 16'h0010, 16'hFFFF, 1'b1, 1'b1, 16'h5A5A, 16'h00C3};
    vecs[12] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 16'h00C3};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFF, 16'h5500, 1'b0, 1'b1, 16'h5A5A, 16'h55C3};
    vecs[14] = '{1'b1, 1'b0, 16'h0001, 16'h1111, 1'b0, 1'b0, 16'h5A5A, 16'h55C3};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset data", 32'(data), 32'h0);
    check("reset hex", 32'(hex), 32'h0);
    check("reset ready0", 32'(ready0), 32'd0);

    foreach (vecs[i]) begin
      access(vecs[i], lat, lat0, rd, rd0);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(WS + 1));
      check($sformatf("v%0d latency0", i), 32'(lat0), 32'd1);
      check($sformatf("v%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d rdata0", i), 32'(rd0), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d hex", i), 32'(hex), 32'(vecs[i].exp_hex));
      check($sformatf("v%0d hex0", i), 32'(hex0), 32'(vecs[i].exp_hex));
    end

    // Held strobes: one pulse per assertion, a fresh pulse after release.
    @(negedge Clk);
    CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 16'h0005; UB = 1'b0; LB = 1'b0;
    n = 0; n0 = 0;
    repeat (20) begin @(posedge Clk); #1; n += int'(ready); n0 += int'(ready0); end
    check("held pulses", 32'(n), 32'd1);
    check("held pulses0", 32'(n0), 32'd1);
    check("held rdata", 32'(data), 32'h0777);
    @(negedge Clk);
    CE = 1'b1;
    @(negedge Clk);
    CE = 1'b0;
    n = 0; n0 = 0;
    repeat (10) begin @(posedge Clk); #1; n += int'(ready); n0 += int'(ready0); end
    check("reassert pulses", 32'(n), 32'd1);
    check("reassert pulses0", 32'(n0), 32'd1);
    release_bus();

    // Reset while both DUTs are in BUSY aborts the write and clears HEX_out.
    @(negedge Clk);
    CE = 1'b0; OE = 1'b1; WE = 1'b0; ADDR = 16'h0001; Data_to_SRAM = 16'hFFFF;
    UB = 1'b0; LB = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(negedge Clk);
    CE = 1'b1; WE = 1'b1;
    n = 0; n0 = 0;
    repeat (3) begin @(posedge Clk); #1; n += int'(ready); n0 += int'(ready0); end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) begin @(posedge Clk); #1; n += int'(ready); n0 += int'(ready0); end
    check("abort pulses", 32'(n), 32'd0);
    check("abort pulses0", 32'(n0), 32'd0);
    check("abort hex", 32'(hex), 32'h0);
    check("abort hex0", 32'(hex0), 32'h0);
    check("abort data", 32'(data), 32'h0);

    v = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h0000};
    access(v, lat, lat0, rd, rd0);
    check("post-abort latency", 32'(lat), 32'(WS + 1));
    check("post-abort rdata", 32'(rd), 32'h1111);
    check("post-abort rdata0", 32'(rd0), 32'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
